seg7_readback_decoder: RTL and testbench
========================================

Name: seg7_readback_decoder

Overview:
- Readback decoder for the active-low 7-segment digit buses that the board display drivers generate.
- Samples NUM_DIGITS segment buses and filters each digit for stability. Each digit is decoded back to a nibble plus a class: hex glyph, digital dash (LOW/HIGH), blank or illegal.
- Results go out on a valid/ready stream.
- Used in loopback self-test and in the on-chip display checker next to the dithering datapath.

Parameters:
- NUM_DIGITS, 6, number of digit buses monitored.
- STABLE_CYCLES, 4, consecutive identical samples required before a digit commits (legal range 2..255).

Ports:
- Clk  in  1  system clock; all logic on the rising edge.
- Reset  in  1  asynchronous, active-high reset.
- seg_in  in  7*NUM_DIGITS  segment buses, active-low. Digit i occupies bits [7i+6:7i]; within a digit, bit 6 = g ... bit 0 = a.
- out_valid  out  1  snapshot available.
- out_ready  in  1  consumer accepts the snapshot when out_valid && out_ready.
- out_value  out  4*NUM_DIGITS  decoded nibble per digit.
- out_class  out  2*NUM_DIGITS  per digit: 0 HEX, 1 DIG, 2 BLANK, 3 ILLEGAL.
- overrun  out  1  sticky; a commit occurred while a snapshot was stalled.
- clear_overrun  in  1  synchronous clear for overrun.

Behaviour:
- Async Reset, immediate on assertion:
  - out_valid=0, overrun=0.
  - out_value=0; out_class=2 (BLANK) for all digits.
  - Internal sample registers = 7'h7F; stability counters = 0.
  - Committed pattern per digit = 7'h7F.
- Reset mid-operation aborts any pending snapshot; no partial result is output.
- Per-digit sampling:
  - seg_in is registered once per cycle into seg_q.
  - If seg_q_next != seg_q, the counter goes to 0. Otherwise it increments, saturating at STABLE_CYCLES-1.
- Commit condition: the counter reaches STABLE_CYCLES-1 and seg_q differs from the committed pattern.
  - Effect: the pattern is copied to the committed register and that digit's commit strobe fires for one cycle.
  - A pattern that returns to the committed value does not commit again.
  - Glitches shorter than STABLE_CYCLES samples never commit.
- Latency: a new pattern held on seg_in for STABLE_CYCLES consecutive rising edges commits on the edge after the last of them. out_valid is high after the following edge, provided the stream is not stalled.
- Decode table (committed pattern -> class, value):
  - 0x40->HEX,0; 0x79->1; 0x24->2; 0x30->3; 0x19->4; 0x12->5; 0x02->6; 0x78->7; 0x00->8; 0x10->9; 0x08->A; 0x03->b; 0x46->C; 0x21->d; 0x06->E; 0x0E->F.
  - 0x77->DIG,0 (LOW, bottom dash); 0x7E->DIG,1 (HIGH, top dash).
  - 0x7F->BLANK,0.
  - Anything else->ILLEGAL,0.
- Snapshot loading: if any digit commits in a cycle and (!out_valid || out_ready), then on the next edge:
  - out_value/out_class load the decode of all committed patterns together;
  - out_valid=1.
- Accept without new commit: out_valid drops on the next edge.
- Stall (out_valid && !out_ready while a commit occurs):
  - out_value/out_class hold their current values;
  - overrun sets;
  - a pending flag sets.
- Pending flag: when the current snapshot is accepted, the snapshot reloads from the latest committed state and out_valid stays 1. This means coalescing, not queueing: only the latest state is delivered.
- Simultaneous commits on several digits in the same cycle produce exactly one snapshot.
- Outputs are stable while out_valid && !out_ready (standard valid/ready rules).
- clear_overrun wins over a same-cycle overrun set.

Test Plan:
- Reset, then hold digit0=0x24 for 4 cycles with out_ready=1 -> exactly one out_valid pulse. Digit0 class=HEX, value=2; other digits BLANK, value 0. out_valid rises 5 edges after the first sample.
- Drive digit1 0x7E->0x77 with each pattern held 3 cycles, STABLE_CYCLES=4 -> no out_valid. Then hold 0x77 for 4 cycles -> one snapshot with digit1 DIG, value 0.
- Digit2=0x55 held 4 cycles -> class ILLEGAL, value 0. Sweep all 16 hex glyphs -> values 0..F in order.
- out_ready=0, commit digit0=0x79, then commit digit0=0x30 -> overrun=1 and out_value still holds 1. Raise out_ready -> the next snapshot shows 3; out_valid stays high across the accept edge.
- Assert Reset while a snapshot is stalled -> out_valid=0 and all classes BLANK immediately. After release, held patterns re-commit after STABLE_CYCLES.
- Change digits 0 and 3 on the same edge -> a single snapshot containing both new values.

Source files
------------

// File: rtl/seg7_readback_decoder.sv
// Readback decoder for active-low 7-segment digit buses: per-digit stability filter,
// glyph decode, and a coalescing valid/ready snapshot stream.
module seg7_readback_decoder #(
    parameter int unsigned NUM_DIGITS    = 6,
    parameter int unsigned STABLE_CYCLES = 4
) (
    input  logic                    Clk,
    input  logic                    Reset,
    input  logic [7*NUM_DIGITS-1:0] seg_in,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [4*NUM_DIGITS-1:0] out_value,
    output logic [2*NUM_DIGITS-1:0] out_class,
    output logic                    overrun,
    input  logic                    clear_overrun
);

    localparam logic [7:0] CntMax     = 8'(STABLE_CYCLES - 1);
    localparam logic [1:0] ClsHex     = 2'd0;
    localparam logic [1:0] ClsDig     = 2'd1;
    localparam logic [1:0] ClsBlank   = 2'd2;
    localparam logic [1:0] ClsIllegal = 2'd3;

    // Returns {class, value} for one committed pattern.
    function automatic logic [5:0] decode(input logic [6:0] pat);
        logic [5:0] r;
        unique case (pat)
            7'h40:   r = {ClsHex, 4'h0};
            7'h79:   r = {ClsHex, 4'h1};
            7'h24:   r = {ClsHex, 4'h2};
            7'h30:   r = {ClsHex, 4'h3};
            7'h19:   r = {ClsHex, 4'h4};
            7'h12:   r = {ClsHex, 4'h5};
            7'h02:   r = {ClsHex, 4'h6};
            7'h78:   r = {ClsHex, 4'h7};
            7'h00:   r = {ClsHex, 4'h8};
            7'h10:   r = {ClsHex, 4'h9};
            7'h08:   r = {ClsHex, 4'hA};
            7'h03:   r = {ClsHex, 4'hB};
            7'h46:   r = {ClsHex, 4'hC};
            7'h21:   r = {ClsHex, 4'hD};
            7'h06:   r = {ClsHex, 4'hE};
            7'h0E:   r = {ClsHex, 4'hF};
            7'h77:   r = {ClsDig, 4'h0};
            7'h7E:   r = {ClsDig, 4'h1};
            7'h7F:   r = {ClsBlank, 4'h0};
            default: r = {ClsIllegal, 4'h0};
        endcase
        return r;
    endfunction

    logic [7*NUM_DIGITS-1:0] seg_q, seg_d;
    logic [8*NUM_DIGITS-1:0] cnt_q, cnt_d;
    logic [7*NUM_DIGITS-1:0] committed_q, committed_d;
    logic [NUM_DIGITS-1:0]   commit_q, commit_d;
    logic                    valid_q, valid_d;
    logic                    pending_q, pending_d;
    logic                    overrun_q, overrun_d;
    logic [4*NUM_DIGITS-1:0] value_q, value_d;
    logic [2*NUM_DIGITS-1:0] class_q, class_d;
    logic [4*NUM_DIGITS-1:0] snap_val;
    logic [2*NUM_DIGITS-1:0] snap_cls;
    logic                    any_commit;

    always_comb begin
        seg_d       = seg_in;
        cnt_d       = cnt_q;
        committed_d = committed_q;
        commit_d    = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (seg_in[7*i +: 7] != seg_q[7*i +: 7]) begin
                cnt_d[8*i +: 8] = 8'd0;
            end else if (cnt_q[8*i +: 8] < CntMax) begin
                cnt_d[8*i +: 8] = cnt_q[8*i +: 8] + 8'd1;
            end
            commit_d[i] = (cnt_q[8*i +: 8] == CntMax) &&
                          (seg_q[7*i +: 7] != committed_q[7*i +: 7]);
            if (commit_d[i]) begin
                committed_d[7*i +: 7] = seg_q[7*i +: 7];
            end
        end
    end

    always_comb begin
        snap_val = '0;
        snap_cls = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            {snap_cls[2*i +: 2], snap_val[4*i +: 4]} = decode(committed_q[7*i +: 7]);
        end
    end

    assign any_commit = |commit_q;

    // Pending coalesces stalled commits: on accept we reload from the latest committed state.
    always_comb begin
        valid_d   = valid_q;
        pending_d = pending_q;
        overrun_d = overrun_q;
        value_d   = value_q;
        class_d   = class_q;
        if (any_commit && (!valid_q || out_ready)) begin
            valid_d   = 1'b1;
            pending_d = 1'b0;
            value_d   = snap_val;
            class_d   = snap_cls;
        end else if (any_commit) begin
            overrun_d = 1'b1;
            pending_d = 1'b1;
        end else if (valid_q && out_ready) begin
            if (pending_q) begin
                value_d   = snap_val;
                class_d   = snap_cls;
                pending_d = 1'b0;
            end else begin
                valid_d = 1'b0;
            end
        end
        if (clear_overrun) begin
            overrun_d = 1'b0;
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            seg_q       <= '1;
            cnt_q       <= '0;
            committed_q <= '1;
            commit_q    <= '0;
            valid_q     <= 1'b0;
            pending_q   <= 1'b0;
            overrun_q   <= 1'b0;
            value_q     <= '0;
            class_q     <= {NUM_DIGITS{ClsBlank}};
        end else begin
            seg_q       <= seg_d;
            cnt_q       <= cnt_d;
            committed_q <= committed_d;
            commit_q    <= commit_d;
            valid_q     <= valid_d;
            pending_q   <= pending_d;
            overrun_q   <= overrun_d;
            value_q     <= value_d;
            class_q     <= class_d;
        end
    end

    assign out_valid = valid_q;
    assign out_value = value_q;
    assign out_class = class_q;
    assign overrun   = overrun_q;

endmodule

// File: tb/tb_seg7_readback_decoder.sv
// Directed self-checking bench for seg7_readback_decoder with hand-computed expectations.
module tb_seg7_readback_decoder;

    localparam int N = 6;

    logic           Clk = 1'b0;
    logic           Reset = 1'b1;
    logic [7*N-1:0] seg_in = '1;
    logic           out_valid;
    logic           out_ready = 1'b1;
    logic [4*N-1:0] out_value;
    logic [2*N-1:0] out_class;
    logic           overrun;
    logic           clear_overrun = 1'b0;

    int total = 0;
    int bad   = 0;

    seg7_readback_decoder #(
        .NUM_DIGITS   (N),
        .STABLE_CYCLES(4)
    ) dut (
        .Clk          (Clk),
        .Reset        (Reset),
        .seg_in       (seg_in),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_value    (out_value),
        .out_class    (out_class),
        .overrun      (overrun),
        .clear_overrun(clear_overrun)
    );

    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge Clk);
        #1;
    endtask

    task automatic set_digit(input int i, input logic [6:0] pat);
        seg_in[7*i +: 7] = pat;
    endtask

    task automatic wait_valid(input string tag);
        int k = 0;
        while (!out_valid && k < 20) begin
            step(1);
            k++;
        end
        check(tag, 32'(out_valid), 32'd1);
    endtask

    logic [6:0] glyphs [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
    logic [6:0] glitch [3] = '{7'h7E, 7'h77, 7'h7E};

    initial begin
        int seen;

        // Reset state
        step(2);
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_overrun", 32'(overrun), 32'd0);
        check("rst_value", 32'(out_value), 32'h0);
        check("rst_class", 32'(out_class), 32'hAAA);
        Reset = 1'b0;
        step(1);

        // Single commit latency: valid appears 5 edges after the first sample
        set_digit(0, 7'h24);
        step(5);
        check("lat_not_yet", 32'(out_valid), 32'd0);
        step(1);
        check("lat_valid", 32'(out_valid), 32'd1);
        check("lat_value", 32'(out_value), 32'h000002);
        check("lat_class", 32'(out_class), 32'hAA8);
        step(1);
        check("lat_drop", 32'(out_valid), 32'd0);

        // Short glitches never commit
        seen = 0;
        for (int g = 0; g < 3; g++) begin
            set_digit(1, glitch[g]);
            for (int c = 0; c < 3; c++) begin
                step(1);
                seen += int'(out_valid);
            end
        end
        check("glitch_none", 32'(seen), 32'd0);
        set_digit(1, 7'h77);
        step(5);
        check("dig_not_yet", 32'(out_valid), 32'd0);
        step(1);
        check("dig_valid", 32'(out_valid), 32'd1);
        check("dig_value", 32'(out_value), 32'h000002);
        check("dig_class", 32'(out_class), 32'hAA4);
        step(1);

        // Illegal pattern
        set_digit(2, 7'h55);
        wait_valid("ill_valid");
        check("ill_class", 32'(out_class[5:4]), 32'd3);
        check("ill_value", 32'(out_value[11:8]), 32'd0);
        step(1);

        // Glyph sweep on digit 2
        for (int j = 0; j < 16; j++) begin
            set_digit(2, glyphs[j]);
            wait_valid("sweep_valid");
            check("sweep_value", 32'(out_value[11:8]), 32'(j));
            check("sweep_class", 32'(out_class[5:4]), 32'd0);
            step(1);
        end

        // Stall, overrun, and coalesced reload on accept
        check("ovr_pre", 32'(overrun), 32'd0);
        out_ready = 1'b0;
        set_digit(0, 7'h79);
        wait_valid("stall_valid");
        check("stall_v1", 32'(out_value[3:0]), 32'd1);
        set_digit(0, 7'h30);
        step(7);
        check("ovr_set", 32'(overrun), 32'd1);
        check("stall_hold_valid", 32'(out_valid), 32'd1);
        check("stall_hold_value", 32'(out_value[3:0]), 32'd1);
        out_ready = 1'b1;
        step(1);
        check("reload_valid", 32'(out_valid), 32'd1);
        check("reload_value", 32'(out_value[3:0]), 32'd3);
        step(1);
        check("reload_drop", 32'(out_valid), 32'd0);
        check("ovr_sticky", 32'(overrun), 32'd1);
        clear_overrun = 1'b1;
        step(1);
        clear_overrun = 1'b0;
        check("ovr_clear", 32'(overrun), 32'd0);

        // Reset while a snapshot is stalled
        out_ready = 1'b0;
        set_digit(3, 7'h19);
        wait_valid("rstmid_valid");
        Reset = 1'b1;
        #1;
        check("rstmid_valid_low", 32'(out_valid), 32'd0);
        check("rstmid_class", 32'(out_class), 32'hAAA);
        out_ready = 1'b1;
        step(2);
        Reset = 1'b0;
        step(5);
        check("recommit_not_yet", 32'(out_valid), 32'd0);
        step(1);
        check("recommit_valid", 32'(out_valid), 32'd1);
        check("recommit_value", 32'(out_value), 32'h004F03);
        check("recommit_class", 32'(out_class), 32'hA04);
        step(1);

        // Simultaneous commits on digits 0 and 3 yield one snapshot
        set_digit(0, 7'h12);
        set_digit(3, 7'h00);
        step(5);
        check("simul_not_yet", 32'(out_valid), 32'd0);
        step(1);
        check("simul_valid", 32'(out_valid), 32'd1);
        check("simul_value", 32'(out_value), 32'h008F05);
        seen = 0;
        for (int c = 0; c < 6; c++) begin
            step(1);
            seen += int'(out_valid);
        end
        check("simul_single", 32'(seen), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
